// File: rtl/axi_rr_req_arbiter.sv
// axi_rr_req_arbiter: round-robin valid/ready arbiter with a transfer lock
// that holds the selection from first presentation until the last beat is accepted.
module axi_rr_req_arbiter #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(N_INPUTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_INPUTS-1:0]            valid_i,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] data_i,
    input  logic [N_INPUTS-1:0]            last_i,
    output logic [N_INPUTS-1:0]            ready_o,
    output logic                           valid_o,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic                           last_o,
    output logic [IDX_W-1:0]               idx_o,
    input  logic                           ready_i
);
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d, sel;
    logic                  lock_q, lock_d, found, hs;
    logic [IDX_W:0]        cand;
    logic [DATA_WIDTH-1:0] data_a [N_INPUTS];

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_unpack
        assign data_a[i] = data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan one wider than IDX_W so the wrap stays exact for non-power-of-2 N_INPUTS.
    always_comb begin
        sel   = rr_ptr_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_INPUTS)) cand = cand - (IDX_W+1)'(N_INPUTS);
            if (!found && valid_i[cand[IDX_W-1:0]]) begin
                sel   = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
        if (lock_q) sel = lock_idx_q;
    end

    assign idx_o   = sel;
    assign valid_o = valid_i[sel];
    assign last_o  = last_i[sel];
    assign data_o  = data_a[sel];
    assign hs      = valid_o & ready_i;

    always_comb begin
        ready_o      = '0;
        ready_o[sel] = ready_i & valid_o;
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (hs && last_o) begin
            lock_d   = 1'b0;
            rr_ptr_d = (sel == IDX_W'(N_INPUTS-1)) ? '0 : sel + 1'b1;
        end else if (valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
endmodule

// File: tb/tb_axi_rr_req_arbiter.sv
// tb_axi_rr_req_arbiter: directed vectors for a 4-input and a 3-input arbiter.
module tb_axi_rr_req_arbiter;
    localparam int DW = 32;

    typedef struct packed {
        logic [3:0] v;
        logic [3:0] l;
        logic       r;
        logic       ev;
        logic [1:0] eidx;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    valid_i, last_i, ready_o;
    logic [4*DW-1:0] data_i;
    logic          valid_o, last_o, ready_i;
    logic [DW-1:0] data_o;
    logic [1:0]    idx_o;

    logic [2:0]    v3, l3, r3o;
    logic [3*DW-1:0] d3;
    logic          vo3, lo3, ri3;
    logic [DW-1:0] do3;
    logic [1:0]    io3;

    int checks = 0;
    int errors = 0;
    vec_t vt[$];

    always #5 clk = ~clk;

    axi_rr_req_arbiter #(.N_INPUTS(4), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i), .last_i(last_i),
        .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .last_o(last_o),
        .idx_o(idx_o), .ready_i(ready_i)
    );

    axi_rr_req_arbiter #(.N_INPUTS(3), .DATA_WIDTH(DW)) dut3 (
        .clk(clk), .rst_n(rst_n), .valid_i(v3), .data_i(d3), .last_i(l3),
        .ready_o(r3o), .valid_o(vo3), .data_o(do3), .last_o(lo3),
        .idx_o(io3), .ready_i(ri3)
    );

    function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic r, logic ev, logic [1:0] e);
        mk = '{v: v, l: l, r: r, ev: ev, eidx: e};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        valid_i = t.v;
        last_i  = t.l;
        ready_i = t.r;
        @(negedge clk);
        chk({tag, " valid_o"}, 64'(valid_o), 64'(t.ev));
        chk({tag, " idx_o"}, 64'(idx_o), 64'(t.eidx));
        chk({tag, " data_o"}, 64'(data_o), 64'(32'hC0DE_0000 + 32'(t.eidx)));
        chk({tag, " last_o"}, 64'(last_o), 64'(t.l[t.eidx]));
        if (t.ev) chk({tag, " ready_o"}, 64'(ready_o), 64'(t.r ? (4'b0001 << t.eidx) : 4'b0000));
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) data_i[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
        for (int i = 0; i < 3; i++) d3[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
        valid_i = '0; last_i = 4'b0001; ready_i = 1'b0;
        v3 = '0; l3 = 3'b111; ri3 = 1'b0;

        for (int i = 0; i < 8; i++) vt.push_back(mk(4'b1111, 4'b1111, 1'b1, 1'b1, 2'(i % 4)));
        vt.push_back(mk(4'b0010, 4'b1111, 1'b1, 1'b1, 2'd1));
        vt.push_back(mk(4'b0000, 4'b1111, 1'b0, 1'b0, 2'd2));
        vt.push_back(mk(4'b0011, 4'b1111, 1'b1, 1'b1, 2'd0));
        vt.push_back(mk(4'b0000, 4'b1111, 1'b0, 1'b0, 2'd1));
        vt.push_back(mk(4'b0011, 4'b1111, 1'b1, 1'b1, 2'd1));
        vt.push_back(mk(4'b0000, 4'b1111, 1'b0, 1'b0, 2'd2));
        vt.push_back(mk(4'b0010, 4'b1111, 1'b0, 1'b1, 2'd1));
        vt.push_back(mk(4'b0011, 4'b1111, 1'b0, 1'b1, 2'd1));
        vt.push_back(mk(4'b0011, 4'b1111, 1'b0, 1'b1, 2'd1));
        vt.push_back(mk(4'b0011, 4'b1111, 1'b1, 1'b1, 2'd1));
        vt.push_back(mk(4'b0000, 4'b1111, 1'b0, 1'b0, 2'd2));
        vt.push_back(mk(4'b1100, 4'b0000, 1'b1, 1'b1, 2'd2));
        vt.push_back(mk(4'b1100, 4'b0000, 1'b1, 1'b1, 2'd2));
        vt.push_back(mk(4'b1000, 4'b0000, 1'b1, 1'b0, 2'd2));
        vt.push_back(mk(4'b1100, 4'b0000, 1'b1, 1'b1, 2'd2));
        vt.push_back(mk(4'b1100, 4'b0100, 1'b1, 1'b1, 2'd2));
        vt.push_back(mk(4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3));
        vt.push_back(mk(4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset valid_o", 64'(valid_o), 64'd0);
        chk("reset idx_o", 64'(idx_o), 64'd0);
        chk("reset ready_o", 64'(ready_o), 64'd0);
        chk("reset data_o", 64'(data_o), 64'(32'hC0DE_0000));
        chk("reset last_o", 64'(last_o), 64'd1);
        chk("reset idx3", 64'(io3), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("vec%0d", i));

        apply(mk(4'b0001, 4'b1111, 1'b1, 1'b1, 2'd0), "rst_pre0");
        apply(mk(4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2), "rst_pre1");
        apply(mk(4'b1111, 4'b0000, 1'b0, 1'b1, 2'd2), "rst_pre2");
        #2 rst_n = 1'b0;
        #1;
        chk("async rst idx_o", 64'(idx_o), 64'd0);
        chk("async rst valid_o", 64'(valid_o), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply(mk(4'b1111, 4'b1111, 1'b0, 1'b1, 2'd0), "rst_post0");
        apply(mk(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0), "rst_post1");
        apply(mk(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1), "rst_post2");

        v3 = 3'b111; ri3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("n3 seq%0d idx", k), 64'(io3), 64'(k % 3));
            chk($sformatf("n3 seq%0d valid", k), 64'(vo3), 64'd1);
            @(posedge clk);
            #1;
        end
        v3 = 3'b000; ri3 = 1'b0;
        @(negedge clk);
        chk("n3 ptr idle", 64'(io3), 64'd1);
        @(posedge clk);
        #1 v3 = 3'b001; ri3 = 1'b1;
        @(negedge clk);
        chk("n3 wrap scan idx", 64'(io3), 64'd0);
        @(posedge clk);
        #1 v3 = 3'b100;
        @(negedge clk);
        chk("n3 after wrap idx", 64'(io3), 64'd2);
        @(posedge clk);
        #1 v3 = 3'b000; ri3 = 1'b0;
        @(negedge clk);
        chk("n3 ptr wraps to 0", 64'(io3), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
